// File: rtl/falling_column_if.sv
// falling_column_if
// Groups the game-facing signals of one falling column so the column can be
// dropped into the game top with a single connection.
//   user_input : player switch value, already synchronous to the clock
//   ypos       : current row of the falling letter
//   letter     : current target byte
//   correct    : one-cycle pulse when the switches match the letter
//   game_over  : high from a miss until reset
// Modports:
//   master : the side driving the switches and consuming the column state
//   slave  : the falling column itself
interface falling_column_if;
    logic [7:0] user_input;
    logic [4:0] ypos;
    logic [7:0] letter;
    logic       correct;
    logic       game_over;

    modport master (
        output user_input,
        input  ypos,
        input  letter,
        input  correct,
        input  game_over
    );

    modport slave (
        input  user_input,
        output ypos,
        output letter,
        output correct,
        output game_over
    );
endinterface

// File: rtl/falling_column.sv
// falling_column
// One falling target byte ("letter") of the bit-flipping game. A pseudo-random
// nonzero byte is picked from an 8-bit LFSR and steps down one row every tick
// period. A match between the player's switches and the letter pulses
// `correct` and respawns a new letter; reaching the bottom row unmatched
// latches `game_over` until reset.
//
// Ports:
//   clock        : system clock
//   reset_signal : asynchronous, active-high reset (also the game restart)
//   col          : falling_column_if.slave (user_input in; ypos, letter,
//                  correct, game_over out)
//
// Parameters:
//   TICK_DIV : clock cycles per one-row fall step (4..2^26)
//   MAX_Y    : last row index (fits in 5 bits)
//   SEED     : LFSR reset value (nonzero)
//
// Optional feature, macro FALLING_COLUMN_SPEEDUP_EN:
//   When defined, the fall period shortens by TICK_DIV/16 on every correct
//   match, never going below TICK_DIV/4. The shortened period takes effect on
//   the next letter. When undefined the period is the constant TICK_DIV.
module falling_column #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned MAX_Y    = 29,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic             clock,
    input  logic             reset_signal,
    falling_column_if.slave  col
);

    typedef enum logic [1:0] {
        SPAWN   = 2'd0,
        FALLING = 2'd1,
        OVER    = 2'd2
    } state_t;

    localparam logic [25:0] TICK_LAST = 26'(TICK_DIV - 1);
    localparam logic [4:0]  Y_LAST    = 5'(MAX_Y);

    state_t      state;
    state_t      state_next;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_next;
    logic [25:0] tick_cnt;
    logic [25:0] tick_cnt_next;
    logic [7:0]  letter_q;
    logic [7:0]  letter_next;
    logic [4:0]  ypos_q;
    logic [4:0]  ypos_next;
    logic        correct_q;
    logic        correct_next;
    logic        game_over_q;
    logic        game_over_next;
    logic [25:0] period_last;
    logic        tick;
    logic        match;

    assign match = (col.user_input == letter_q);
    assign tick  = (state == FALLING) && (tick_cnt == period_last);

`ifdef FALLING_COLUMN_SPEEDUP_EN
    // The period register holds (period - 1) so that the full legal range of
    // TICK_DIV, including 2^26, fits in 26 bits.
    localparam logic [25:0] STEP_DEC   = 26'(TICK_DIV / 16);
    localparam logic [25:0] FLOOR_LAST = 26'(TICK_DIV / 4 - 1);

    logic [25:0] step_last;
    logic [25:0] step_last_next;

    assign period_last = step_last;

    // Shorten the fall period on every match, clamped at a quarter of the
    // base period. A match always leaves FALLING, so the new value is only
    // seen from the next letter onwards.
    always_comb begin
        step_last_next = step_last;
        if (state == FALLING && match) begin
            if (step_last >= FLOOR_LAST + STEP_DEC) begin
                step_last_next = step_last - STEP_DEC;
            end else begin
                step_last_next = FLOOR_LAST;
            end
        end
    end

    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            step_last <= TICK_LAST;
        end else begin
            step_last <= step_last_next;
        end
    end
`else
    assign period_last = TICK_LAST;
`endif

    // State and datapath registers. Everything is cleared asynchronously so a
    // restart mid-fall or mid-pulse leaves nothing behind.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state       <= SPAWN;
            lfsr        <= SEED;
            tick_cnt    <= 26'd0;
            letter_q    <= 8'h00;
            ypos_q      <= 5'd0;
            correct_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state       <= state_next;
            lfsr        <= lfsr_next;
            tick_cnt    <= tick_cnt_next;
            letter_q    <= letter_next;
            ypos_q      <= ypos_next;
            correct_q   <= correct_next;
            game_over_q <= game_over_next;
        end
    end

    // Next-state logic. The LFSR free-runs in every state so a retried spawn
    // sees a fresh value. A match in FALLING is checked before the tick, so a
    // match on the final row beats the miss.
    always_comb begin
        state_next     = state;
        lfsr_next      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        tick_cnt_next  = tick_cnt;
        letter_next    = letter_q;
        ypos_next      = ypos_q;
        correct_next   = 1'b0;
        game_over_next = game_over_q;

        case (state)
            SPAWN: begin
                // Refusing a letter equal to the switches stops a new letter
                // from scoring the instant it appears.
                if (lfsr != col.user_input) begin
                    letter_next   = lfsr;
                    ypos_next     = 5'd0;
                    tick_cnt_next = 26'd0;
                    state_next    = FALLING;
                end
            end

            FALLING: begin
                if (match) begin
                    correct_next = 1'b1;
                    state_next   = SPAWN;
                end else begin
                    tick_cnt_next = tick ? 26'd0 : tick_cnt + 26'd1;
                    if (tick) begin
                        if (ypos_q < Y_LAST) begin
                            ypos_next = ypos_q + 5'd1;
                        end else begin
                            game_over_next = 1'b1;
                            state_next     = OVER;
                        end
                    end
                end
            end

            OVER: begin
                state_next = OVER;
            end

            default: begin
                state_next = SPAWN;
            end
        endcase
    end

    assign col.ypos      = ypos_q;
    assign col.letter    = letter_q;
    assign col.correct   = correct_q;
    assign col.game_over = game_over_q;

endmodule

// File: tb/tb_falling_column.sv
// tb_falling_column
// Bench for falling_column with a short period (TICK_DIV=4, MAX_Y=3). A
// behavioural reference model runs on every clock edge and pushes the expected
// outputs into a scoreboard queue; a monitor pops and compares them on the
// falling edge. Directed sequences cover reset, the miss timing, the frozen
// game-over state, a match, a spawn collision, the final-row race and
// asynchronous reset, followed by a randomised phase.
module tb_falling_column;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned MAX_Y    = 3;
    localparam logic [7:0]  SEED     = 8'hA5;

    typedef struct packed {
        logic [4:0] ypos;
        logic [7:0] letter;
        logic       correct;
        logic       game_over;
    } snap_t;

    logic clock = 1'b0;
    logic reset_signal;

    falling_column_if col ();

    falling_column #(
        .TICK_DIV (TICK_DIV),
        .MAX_Y    (MAX_Y),
        .SEED     (SEED)
    ) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .col          (col)
    );

    int checks   = 0;
    int failures = 0;

    snap_t sb[$];

    int         m_state  = 0;
    logic [7:0] m_lfsr   = SEED;
    logic [7:0] m_cur    = 8'h00;
    logic [7:0] m_letter = 8'h00;
    logic [4:0] m_ypos   = 5'd0;
    logic       m_correct = 1'b0;
    logic       m_go     = 1'b0;
    int         m_left   = 0;
    int         m_period = TICK_DIV;
    snap_t      m_snap;

    // 50 MHz clock.
    always #10 clock = ~clock;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] value);
        col.user_input = value;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Reference model: a down-counting row timer and a polynomial-mask LFSR.
    // It samples the switches on the same edge as the design and queues the
    // outputs the design should show after that edge.
    always @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            m_state   = 0;
            m_lfsr    = SEED;
            m_letter  = 8'h00;
            m_ypos    = 5'd0;
            m_correct = 1'b0;
            m_go      = 1'b0;
            m_left    = 0;
            m_period  = TICK_DIV;
            sb.delete();
        end else begin
            m_cur     = m_lfsr;
            m_correct = 1'b0;
            case (m_state)
                0: begin
                    if (m_cur != col.user_input) begin
                        m_letter = m_cur;
                        m_ypos   = 5'd0;
                        m_left   = m_period;
                        m_state  = 1;
                    end
                end
                1: begin
                    if (col.user_input == m_letter) begin
                        m_correct = 1'b1;
                        m_state   = 0;
`ifdef FALLING_COLUMN_SPEEDUP_EN
                        if (m_period - int'(TICK_DIV / 16) > int'(TICK_DIV / 4))
                            m_period = m_period - int'(TICK_DIV / 16);
                        else
                            m_period = int'(TICK_DIV / 4);
`endif
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            m_left = m_period;
                            if (m_ypos < 5'(MAX_Y)) begin
                                m_ypos = m_ypos + 5'd1;
                            end else begin
                                m_go    = 1'b1;
                                m_state = 2;
                            end
                        end
                    end
                end
                default: ;
            endcase
            m_lfsr = {m_cur[6:0], ^(m_cur & 8'hB8)};
            m_snap.ypos      = m_ypos;
            m_snap.letter    = m_letter;
            m_snap.correct   = m_correct;
            m_snap.game_over = m_go;
            sb.push_back(m_snap);
        end
    end

    // Scoreboard monitor: compare design outputs against the queued model
    // results half a cycle after each edge.
    always @(negedge clock) begin
        if (!reset_signal && sb.size() > 0) begin
            snap_t e;
            e = sb.pop_front();
            checkOutput("sb_ypos",      col.ypos,      e.ypos);
            checkOutput("sb_letter",    col.letter,    e.letter);
            checkOutput("sb_correct",   col.correct,   e.correct);
            checkOutput("sb_game_over", col.game_over, e.game_over);
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences followed by a randomised phase.
    initial begin
        int         cycles;
        logic [7:0] old_letter;
        logic [7:0] held;

        applyStimulus(8'h00);
        reset_signal = 1'b1;
        step();
        step();
        checkOutput("rst_ypos",      col.ypos,      0);
        checkOutput("rst_letter",    col.letter,    0);
        checkOutput("rst_correct",   col.correct,   0);
        checkOutput("rst_game_over", col.game_over, 0);

        // First letter appears on the first edge after release.
        reset_signal = 1'b0;
        step();
        checkOutput("first_letter", col.letter, 8'hA5);
        checkOutput("first_ypos",   col.ypos,   0);

        // Miss: one row every TICK_DIV cycles, game over after 16 cycles.
        cycles = 0;
        while (col.game_over !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
            if (cycles < 16 && (cycles % 4) == 0)
                checkOutput("fall_ypos", col.ypos, cycles / 4);
        end
        checkOutput("miss_latency", cycles, 16);

        // Game over ignores the switches entirely.
        applyStimulus(8'hA5);
        step();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'($urandom));
            step();
        end
        checkOutput("over_letter",    col.letter,    8'hA5);
        checkOutput("over_ypos",      col.ypos,      3);
        checkOutput("over_game_over", col.game_over, 1);
        checkOutput("over_correct",   col.correct,   0);

        // Restart and match on row 2.
        applyStimulus(8'h00);
        reset_signal = 1'b1;
        step();
        reset_signal = 1'b0;
        step();
        cycles = 0;
        while (col.ypos !== 5'd2 && cycles < 20) begin
            step();
            cycles++;
        end
        checkOutput("reach_row2", col.ypos, 2);
        applyStimulus(8'hA5);
        step();
        checkOutput("match_pulse", col.correct, 1);
        step();
        checkOutput("match_pulse_end",  col.correct, 0);
        checkOutput("respawn_not_a5",   col.letter != 8'hA5, 1);
        checkOutput("respawn_nonzero",  col.letter != 8'h00, 1);
        checkOutput("respawn_ypos",     col.ypos, 0);

        // Spawn collision: after the match, hold the switches at the LFSR
        // value the spawn will see; the spawn must retry.
        applyStimulus(m_letter);
        step();
        checkOutput("collide_match", col.correct, 1);
        old_letter = m_letter;
        held = m_lfsr;
        applyStimulus(held);
        step();
        checkOutput("collide_hold_letter", col.letter, old_letter);
        step();
        checkOutput("collide_letter_ne", col.letter != held, 1);
        checkOutput("collide_ypos",      col.ypos, 0);

        // Final-row race: match on the same edge as the last tick.
        applyStimulus(8'h00);
        cycles = 0;
        while (!(col.ypos == 5'd3 && m_left == 1) && cycles < 60) begin
            step();
            cycles++;
        end
        checkOutput("race_setup", (col.ypos == 5'd3 && m_left == 1), 1);
        applyStimulus(m_letter);
        step();
        checkOutput("race_correct",   col.correct,   1);
        checkOutput("race_game_over", col.game_over, 0);
        step();
        checkOutput("race_game_over_after", col.game_over, 0);

        // Asynchronous reset in the middle of a fall.
        applyStimulus(8'h00);
        for (int i = 0; i < 6; i++) step();
        #5;
        reset_signal = 1'b1;
        #1;
        checkOutput("async_ypos",   col.ypos,   0);
        checkOutput("async_letter", col.letter, 0);
        step();
        reset_signal = 1'b0;
        step();
        checkOutput("async_release_letter", col.letter, 8'hA5);

        // Asynchronous reset in the middle of a correct pulse.
        applyStimulus(8'hA5);
        step();
        checkOutput("pulse_before_reset", col.correct, 1);
        #3;
        reset_signal = 1'b1;
        #1;
        checkOutput("async_correct", col.correct, 0);
        step();
        reset_signal = 1'b0;
        applyStimulus(8'h00);
        step();
        checkOutput("no_partial_pulse", col.correct, 0);

        // Randomised play; restart whenever the game ends.
        for (int i = 0; i < 400; i++) begin
            if (col.game_over === 1'b1) begin
                reset_signal = 1'b1;
                step();
                reset_signal = 1'b0;
            end
            if ($urandom_range(0, 5) == 0)
                applyStimulus(m_letter);
            else
                applyStimulus(8'($urandom));
            step();
        end

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
